// File: rtl/adc_capture_buffer.sv
// Circular capture buffer for the 12-bit ADC stream.
// Freezes a pre/post window around a rising threshold crossing and streams it out.
module adc_capture_buffer #(
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8,
  parameter int PRE_TRIG = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  input  logic [11:0] threshold,
  input  logic        arm,
  input  logic        abort,
  output logic [11:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last,
  output logic        busy,
  output logic        triggered,
  output logic        capture_done
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARMED,
    POST,
    READ
  } state_t;

  localparam logic [ADDR_W-1:0] PRE_L  = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] POST_L = ADDR_W'(DEPTH - PRE_TRIG);
  localparam logic [ADDR_W:0]   DEP_L  = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [11:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W:0]   rd_cnt;
  logic [11:0]       prev;
  logic              prev_valid;
  logic              writing;
  logic              crossing;
  logic              issue;
  logic              xfer;

  assign writing = sample_valid && !abort &&
                   (state == FILL || state == ARMED || state == POST);
  assign crossing = sample_valid && prev_valid &&
                    (prev < threshold) && (sample >= threshold);
  assign xfer  = rd_valid && rd_ready;
  assign issue = (state == READ) && !abort && (rd_cnt != DEP_L) &&
                 (!rd_valid || rd_ready);

  assign busy         = (state != IDLE);
  assign capture_done = (state == READ);

  always_ff @(posedge clk) begin
    if (writing) begin
      mem[wr_ptr] <= sample;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      trig_addr  <= '0;
      rd_cnt     <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      triggered  <= 1'b0;
    end else begin
      triggered <= 1'b0;
      if (writing) begin
        wr_ptr     <= wr_ptr + 1'b1;
        prev       <= sample;
        prev_valid <= 1'b1;
      end
      if (abort) begin
        state    <= IDLE;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (arm) begin
              state      <= FILL;
              wr_ptr     <= '0;
              pre_cnt    <= '0;
              prev_valid <= 1'b0;
            end
          end
          FILL: begin
            if (sample_valid) begin
              pre_cnt <= pre_cnt + 1'b1;
              if (pre_cnt + 1'b1 == PRE_L) begin
                state <= ARMED;
              end
            end
          end
          ARMED: begin
            if (crossing) begin
              trig_addr <= wr_ptr;
              post_cnt  <= ADDR_W'(1);
              triggered <= 1'b1;
              // A one-sample post window completes on the trigger itself
              if (POST_L == ADDR_W'(1)) begin
                state  <= READ;
                rd_ptr <= wr_ptr - PRE_L;
                rd_cnt <= '0;
              end else begin
                state <= POST;
              end
            end
          end
          POST: begin
            if (sample_valid) begin
              post_cnt <= post_cnt + 1'b1;
              if (post_cnt + 1'b1 == POST_L) begin
                state  <= READ;
                rd_ptr <= trig_addr - PRE_L;
                rd_cnt <= '0;
              end
            end
          end
          READ: begin
            if (issue) begin
              rd_data  <= mem[rd_ptr];
              rd_valid <= 1'b1;
              rd_ptr   <= rd_ptr + 1'b1;
              rd_cnt   <= rd_cnt + 1'b1;
              rd_last  <= (rd_cnt == DEP_L - 1'b1);
            end else if (xfer) begin
              rd_valid <= 1'b0;
            end
            if (xfer && rd_last) begin
              state    <= IDLE;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
